video_timing_gen: RTL

Parametrised raster timing generator for the pixel-output path. It produces HSync, VSync, the current pixel coordinates, an addressable-area flag and line/frame start strobes for any progressive mode defined by its porch and sync parameters. It adds a pixel-clock enable and a synchronous frame restart. It sits at the head of the video pipeline, and every pattern or sprite block keys off its outputs.

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/video_timing_gen_raster_axis.sv | 67 ++++++
 rtl/video_timing_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Mode constants and total-length helpers shared by the raster timing blocks.
package video_timing_pkg;

   // 640x480@60, the default mode
   localparam int VGA_H_ADDR   = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_V_ADDR   = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;

   // 800x600@60
   localparam int SVGA_H_ADDR  = 800;
   localparam int SVGA_H_FRONT = 40;
   localparam int SVGA_H_SYNC  = 128;
   localparam int SVGA_H_BACK  = 88;
   localparam int SVGA_V_ADDR  = 600;
   localparam int SVGA_V_FRONT = 1;
   localparam int SVGA_V_SYNC  = 4;
   localparam int SVGA_V_BACK  = 23;

   // Length of one axis: addressable area plus both porches plus sync.
   function automatic int axis_total(input int addr, input int front, input int sync, input int back);
      return addr + front + sync + back;
   endfunction

   function automatic int h_total(input int addr, input int front, input int sync, input int back);
      return axis_total(addr, front, sync, back);
   endfunction

   function automatic int v_total(input int addr, input int front, input int sync, input int back);
      return axis_total(addr, front, sync, back);
   endfunction

endpackage

// File: rtl/video_timing_gen_raster_axis.sv
// One raster axis: a wrapping position counter with its sync and active
// windows registered from the next-state position so they never lag pos.
module raster_axis
   import video_timing_pkg::*;
#(
   parameter int ADDR  = VGA_H_ADDR,
   parameter int FRONT = VGA_H_FRONT,
   parameter int SYNC  = VGA_H_SYNC,
   parameter int BACK  = VGA_H_BACK,
   parameter bit POL   = 1'b0,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   input  logic         restart,
   output logic [W-1:0] pos,
   output logic         wrap_next,
   output logic         sync,
   output logic         active
);

   localparam int           TOTAL      = axis_total(ADDR, FRONT, SYNC, BACK);
   localparam int           SYNC_START = ADDR + FRONT;
   localparam int           SYNC_END   = SYNC_START + SYNC;
   localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

   logic [W-1:0] pos_reg;
   logic [W-1:0] pos_next;
   logic         sync_reg;
   logic         active_reg;

   // A zero-width sync gives an empty window, so it never asserts.
   function automatic logic in_sync(input logic [W-1:0] p);
      return (int'(p) >= SYNC_START) && (int'(p) < SYNC_END);
   endfunction

   assign wrap_next = (pos_reg == LAST);

   // Next position: restart wins over stepping and wrapping.
   always_comb begin
      pos_next = pos_reg;
      if (restart) begin
         pos_next = '0;
      end else if (step) begin
         pos_next = wrap_next ? '0 : pos_reg + 1'b1;
      end
   end

   // Position, sync and active registered together from pos_next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_reg    <= '0;
         sync_reg   <= ~POL;
         active_reg <= (ADDR > 0);
      end else begin
         pos_reg    <= pos_next;
         sync_reg   <= in_sync(pos_next) ? POL : ~POL;
         active_reg <= (int'(pos_next) < ADDR);
      end
   end

   assign pos    = pos_reg;
   assign sync   = sync_reg;
   assign active = active_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator: horizontal and vertical axes plus
// line/frame start strobes, all registered and mutually aligned.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ADDR    = VGA_H_ADDR,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_ADDR    = VGA_V_ADDR,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int W         = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pix_en,
   input  logic         restart,
   output logic         hsync,
   output logic         vsync,
   output logic [W-1:0] hpos,
   output logic [W-1:0] vpos,
   output logic         display_on,
   output logic         line_start,
   output logic         frame_start
);

   localparam int H_TOTAL = h_total(H_ADDR, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_ADDR, V_FRONT, V_SYNC, V_BACK);

   if ((H_TOTAL > (1 << W)) || (V_TOTAL > (1 << W))) begin : g_size_check
      $error("video_timing_gen: W is too narrow for the mode totals");
   end

   logic h_wrap_next;
   logic v_wrap_next;
   logic h_active;
   logic v_active;
   logic line_start_reg;
   logic frame_start_reg;

   raster_axis #(
      .ADDR(H_ADDR), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HSYNC_POL), .W(W)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (pix_en),
      .restart   (restart),
      .pos       (hpos),
      .wrap_next (h_wrap_next),
      .sync      (hsync),
      .active    (h_active)
   );

   raster_axis #(
      .ADDR(V_ADDR), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VSYNC_POL), .W(W)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (pix_en & h_wrap_next),
      .restart   (restart),
      .pos       (vpos),
      .wrap_next (v_wrap_next),
      .sync      (vsync),
      .active    (v_active)
   );

   // Strobes fire in the cycle after a step lands on column 0 / pixel (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         line_start_reg  <= restart | (pix_en & h_wrap_next);
         frame_start_reg <= restart | (pix_en & h_wrap_next & v_wrap_next);
      end
   end

   assign display_on  = h_active & v_active;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

endmodule
